// File: rtl/axis_gen_pkg.sv
// rtl/axis_gen_pkg.sv - shared types and helpers for the AXIS frame generator
package axis_gen_pkg;

  localparam int unsigned MAX_KEEP = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } gen_state_e;

  typedef enum logic {
    PAT_INC  = 1'b0,
    PAT_FILL = 1'b1
  } pat_mode_e;

  // Last-beat byte enables: low 'rem' lanes set, or all lanes when rem is 0.
  function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned rem,
                                                     input int unsigned keep_width);
    logic [MAX_KEEP-1:0] m;
    for (int unsigned i = 0; i < MAX_KEEP; i++) begin
      m[i] = (rem == 0) ? (i < keep_width) : (i < rem);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// rtl/axis_frame_gen_if.sv - AXI4-Stream bundle with master/slave views
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);

endinterface

// File: rtl/axis_pattern_beat.sv
// rtl/axis_pattern_beat.sv - combinational payload generator for one beat
module axis_pattern_beat
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  pat_mode_e             mode,
  input  logic [7:0]            fill,
  input  logic [7:0]            seq,
  input  logic [7:0]            off_lo,
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [DATA_WIDTH-1:0] data
);

  // Each enabled lane carries either the fill byte or (offset + lane + seq) mod 256.
  always_comb begin
    data = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (keep[i]) begin
        data[i*8 +: 8] = (mode == PAT_FILL) ? fill : (off_lo + seq + 8'(i));
      end
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream burst frame source with registered outputs
module axis_frame_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  cfg_mode,
  input  logic [7:0]            cfg_fill,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  input  logic                  cfg_abort,
  output logic                  stat_busy,
  output logic                  stat_done,
  output logic [CNT_WIDTH-1:0]  stat_frames_sent,
  axis_frame_gen_if.master      m_axis
);

  gen_state_e            state;
  logic [LEN_WIDTH-1:0]  len_q, cur_off, ld_len, ld_off, ld_rem;
  logic [CNT_WIDTH-1:0]  count_q;
  pat_mode_e             mode_q, ld_mode;
  logic [7:0]            fill_q, ld_fill, ld_seq;
  logic                  abort_q, ld_last, hs, more_frames, stop_req;
  logic [KEEP_WIDTH-1:0] ld_keep;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [15:0]           gap_cnt;

  assign hs          = m_axis.tvalid && m_axis.tready;
  assign more_frames = (stat_frames_sent + CNT_WIDTH'(1)) < count_q;
  assign stop_req    = abort_q || cfg_abort;

  // Describe the beat that would be loaded this cycle: first beat of a burst,
  // next beat of the current frame, or first beat of the following frame.
  always_comb begin
    ld_len  = len_q;
    ld_mode = mode_q;
    ld_fill = fill_q;
    ld_off  = '0;
    ld_seq  = stat_frames_sent[7:0];
    if (state == ST_IDLE) begin
      ld_len  = cfg_len;
      ld_mode = pat_mode_e'(cfg_mode);
      ld_fill = cfg_fill;
      ld_seq  = 8'd0;
    end else if (state == ST_SEND) begin
      if (m_axis.tlast) ld_seq = stat_frames_sent[7:0] + 8'd1;
      else              ld_off = cur_off + LEN_WIDTH'(KEEP_WIDTH);
    end
    ld_rem  = ld_len - ld_off;
    ld_last = ld_rem <= LEN_WIDTH'(KEEP_WIDTH);
    ld_keep = ld_last ? KEEP_WIDTH'(keep_mask(32'(ld_rem) % 32'(KEEP_WIDTH), 32'(KEEP_WIDTH)))
                      : '1;
  end

  axis_pattern_beat #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_beat (
    .mode   (ld_mode),
    .fill   (ld_fill),
    .seq    (ld_seq),
    .off_lo (ld_off[7:0]),
    .keep   (ld_keep),
    .data   (ld_data)
  );

  // Burst sequencer; every AXIS and status output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      len_q            <= '0;
      count_q          <= '0;
      mode_q           <= PAT_INC;
      fill_q           <= '0;
      abort_q          <= 1'b0;
      cur_off          <= '0;
      gap_cnt          <= '0;
      stat_busy        <= 1'b0;
      stat_done        <= 1'b0;
      stat_frames_sent <= '0;
      m_axis.tvalid    <= 1'b0;
      m_axis.tlast     <= 1'b0;
      m_axis.tdata     <= '0;
      m_axis.tkeep     <= '0;
      m_axis.tuser     <= '0;
      m_axis.tid       <= '0;
      m_axis.tdest     <= '0;
    end else begin
      stat_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            len_q            <= cfg_len;
            count_q          <= cfg_count;
            mode_q           <= pat_mode_e'(cfg_mode);
            fill_q           <= cfg_fill;
            m_axis.tid       <= cfg_id;
            m_axis.tdest     <= cfg_dest;
            abort_q          <= 1'b0;
            stat_frames_sent <= '0;
            stat_busy        <= 1'b1;
            if (cfg_len == '0 || cfg_count == '0) begin
              state <= ST_DONE;
            end else begin
              m_axis.tvalid <= 1'b1;
              m_axis.tdata  <= ld_data;
              m_axis.tkeep  <= ld_keep;
              m_axis.tlast  <= ld_last;
              m_axis.tuser  <= USER_WIDTH'(1);
              cur_off       <= ld_off;
              state         <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (cfg_abort) abort_q <= 1'b1;
          if (hs) begin
            if (!m_axis.tlast) begin
              m_axis.tdata <= ld_data;
              m_axis.tkeep <= ld_keep;
              m_axis.tlast <= ld_last;
              m_axis.tuser <= '0;
              cur_off      <= ld_off;
            end else begin
              stat_frames_sent <= stat_frames_sent + CNT_WIDTH'(1);
              if (more_frames && !stop_req) begin
                if (GAP_CYCLES > 0) begin
                  m_axis.tvalid <= 1'b0;
                  gap_cnt       <= '0;
                  state         <= ST_GAP;
                end else begin
                  m_axis.tdata <= ld_data;
                  m_axis.tkeep <= ld_keep;
                  m_axis.tlast <= ld_last;
                  m_axis.tuser <= USER_WIDTH'(1);
                  cur_off      <= ld_off;
                end
              end else begin
                m_axis.tvalid <= 1'b0;
                state         <= ST_DONE;
              end
            end
          end
        end
        ST_GAP: begin
          if (stop_req) begin
            abort_q <= 1'b1;
            state   <= ST_DONE;
          end else if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= ld_data;
            m_axis.tkeep  <= ld_keep;
            m_axis.tlast  <= ld_last;
            m_axis.tuser  <= USER_WIDTH'(1);
            cur_off       <= ld_off;
            state         <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          stat_done <= 1'b1;
          stat_busy <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
AXI4-Stream frame source that produces configurable test or fill frames on an AXIS master port. It is the transmitting end for the stream pipeline and feeds register slices, FIFOs and frame checkers downstream. Software or testbench control starts a burst of N frames of L bytes each. Byte-granular lengths are supported, with tkeep on the last beat. Outputs are fully registered and the block honours backpressure.

Parameters:
DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
LEN_WIDTH, 16, frame length field width, in bytes.
CNT_WIDTH, 16, frame count field width.
ID_WIDTH, 8, tid width.
DEST_WIDTH, 8, tdest width.
USER_WIDTH, 1, tuser width; bit 0 is start-of-frame (SOF).
GAP_CYCLES, 0, idle cycles inserted after each frame.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_len  in  LEN_WIDTH  bytes per frame
cfg_count  in  CNT_WIDTH  frames per burst
cfg_mode  in  1  0 = incrementing byte pattern, 1 = constant fill
cfg_fill  in  8  fill byte used in mode 1
cfg_id  in  ID_WIDTH  tid for the burst
cfg_dest  in  DEST_WIDTH  tdest for the burst
cfg_abort  in  1  stop after the current frame
stat_busy  out  1  high outside IDLE
stat_done  out  1  one-cycle pulse at burst end
stat_frames_sent  out  CNT_WIDTH  completed frames in the current or last burst
m_axis_tdata  out  DATA_WIDTH
m_axis_tkeep  out  KEEP_WIDTH
m_axis_tvalid  out  1
m_axis_tready  in  1
m_axis_tlast  out  1
m_axis_tid  out  ID_WIDTH
m_axis_tdest  out  DEST_WIDTH
m_axis_tuser  out  USER_WIDTH

Behaviour:
- Reset values: tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0, tid=0, tdest=0, stat_busy=0, stat_done=0, stat_frames_sent=0; FSM goes to IDLE.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: on cfg_start, latch all cfg_* fields and clear stat_frames_sent.
  - If cfg_len==0 or cfg_count==0: go to DONE and emit no beats.
  - Otherwise load the first beat into the output registers and go to SEND. tvalid is high the cycle after start (latency 1).
- Beats per frame = ceil(len/KEEP_WIDTH).
  - All beats except the last carry tkeep all-ones.
  - The last beat carries tkeep = low (len mod KEEP_WIDTH) bits set, or all-ones when the remainder is 0.
  - tlast is high only on the last beat.
- tuser[0]=1 on the first beat of each frame; all other tuser bits are 0. tid and tdest hold the latched values.
- Pattern mode 0: byte at frame offset k = (k + seq) mod 256, where seq = frame index mod 256, starting at 0. Bytes where tkeep=0 are driven as 0.
- Pattern mode 1: every valid byte = cfg_fill.
- AXIS rule: once tvalid is asserted, all outputs are stable until tvalid && tready. A new beat loads on the handshake cycle, giving 1 beat/cycle at full throughput.
- On the last-beat handshake, stat_frames_sent increments, then:
  - If frames remain and no abort is pending: go to GAP when GAP_CYCLES>0, otherwise present the next frame's first beat in the following cycle (back-to-back, no bubble).
  - Otherwise go to DONE.
- GAP: tvalid=0 for exactly GAP_CYCLES cycles, then present the next frame's first beat.
- cfg_abort in SEND or GAP sets an abort flag.
  - In SEND, the current frame completes normally with tlast, then the FSM goes to DONE.
  - In GAP, the FSM goes to DONE immediately.
  - cfg_abort in IDLE is ignored. Starting a new burst clears the flag.
- DONE: stat_done=1 for one cycle, then IDLE. cfg_start during DONE is ignored.
- rst mid-frame: tvalid drops the next cycle and the frame is truncated; downstream must be reset with it.
- Counters are internally sized to LEN_WIDTH and CNT_WIDTH; no wrap is possible within a burst.

Decomposition:
- Shared package axis_gen_pkg holds:
  - the state enum;
  - the pattern mode enum;
  - a function keep_mask(rem, KEEP_WIDTH) returning the last-beat tkeep.
- One sub-module, axis_pattern_beat: combinational tdata generator from (mode, fill, seq, byte offset, keep).

Test Plan:
- DATA_WIDTH=64, len=20, count=1, mode 0, tready=1 -> 3 beats on consecutive cycles starting at start+1; tkeep FF,FF,0F; bytes 0x00..0x13 with upper bytes of beat 3 = 0; tuser[0] set on beat 1 only; tlast on beat 3; stat_done pulses once; frames_sent=1.
- Same config, tready toggling 1/0 each cycle -> same 3 beats; outputs held constant through every stall cycle; no beat lost or duplicated.
- len=8, count=3, GAP_CYCLES=0 -> 3 single-beat frames on consecutive cycles, each with tlast=1 and tuser[0]=1; byte0 = 0x00, 0x01, 0x02.
- len=16, count=4, GAP_CYCLES=2, abort asserted mid-frame 2 -> frame 2 completes with tlast; no frame 3; frames_sent=2; stat_done pulses once.
- cfg_len=0, count=5 -> tvalid never asserts; stat_done pulses two cycles after start; frames_sent=0.
- rst asserted during beat 2 of a 4-beat frame -> next cycle tvalid=0, stat_busy=0, frames_sent=0; a fresh start then produces a correct frame.
